// File: rtl/video_timing_generator.sv
// video_timing_generator: raster timing (DE/hsync/vsync, x/y, line/frame strobes) for the TMDS transmit path.
// Define VTG_PREFETCH_EN to add next_x/next_y/next_active, which lead x/y/video_data_enable by one cycle.
module video_timing_generator #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit HSYNC_ACTIVE = 1'b0,
    parameter bit VSYNC_ACTIVE = 1'b0,
    parameter int COORD_WIDTH  = 12
) (
    input  logic                   pixel_clock,
    input  logic                   pixel_reset_n,
    input  logic                   enable,
    output logic                   video_data_enable,
    output logic                   hsync,
    output logic                   vsync,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y,
    output logic                   line_start,
    output logic                   frame_start
`ifdef VTG_PREFETCH_EN
    ,
    output logic [COORD_WIDTH-1:0] next_x,
    output logic [COORD_WIDTH-1:0] next_y,
    output logic                   next_active
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [COORD_WIDTH-1:0] H_ACT   = COORD_WIDTH'(H_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] H_SS    = COORD_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] H_SE    = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_WIDTH-1:0] H_LAST  = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_ACT   = COORD_WIDTH'(V_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] V_SS    = COORD_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] V_SE    = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [COORD_WIDTH-1:0] V_LAST  = COORD_WIDTH'(V_TOTAL - 1);

    logic [COORD_WIDTH-1:0] h_cnt, v_cnt;
    logic h_last, v_last, active, h_sync_on, v_sync_on, h_zero;

    always_comb begin
        h_last    = h_cnt == H_LAST;
        v_last    = v_cnt == V_LAST;
        h_zero    = h_cnt == '0;
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_sync_on = (h_cnt >= H_SS) && (h_cnt < H_SE);
        v_sync_on = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    // Outputs decode the pre-increment count, so they trail h_cnt/v_cnt by one cycle.
    always_ff @(posedge pixel_clock or negedge pixel_reset_n) begin
        if (!pixel_reset_n) begin
            h_cnt             <= '0;
            v_cnt             <= '0;
            video_data_enable <= 1'b0;
            hsync             <= ~HSYNC_ACTIVE;
            vsync             <= ~VSYNC_ACTIVE;
            x                 <= '0;
            y                 <= '0;
            line_start        <= 1'b0;
            frame_start       <= 1'b0;
        end else if (enable) begin
            h_cnt             <= h_last ? '0 : h_cnt + 1'b1;
            v_cnt             <= !h_last ? v_cnt : v_last ? '0 : v_cnt + 1'b1;
            video_data_enable <= active;
            hsync             <= h_sync_on ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vsync             <= v_sync_on ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            x                 <= h_cnt;
            y                 <= v_cnt;
            line_start        <= h_zero;
            frame_start       <= h_zero && (v_cnt == '0);
        end else begin
            video_data_enable <= 1'b0;
            line_start        <= 1'b0;
            frame_start       <= 1'b0;
        end
    end

`ifdef VTG_PREFETCH_EN
    // Gated by reset so next_active reads 0 while the block is held in reset.
    assign next_x      = h_cnt;
    assign next_y      = v_cnt;
    assign next_active = active && pixel_reset_n;
`endif
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: scoreboard bench for a small-raster instance and a default 640x480 instance.
module tb_video_timing_generator;
    localparam int SHA = 6, SHF = 2, SHS = 3, SHB = 2, SVA = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48, DVA = 480, DVF = 10, DVS = 2, DVB = 33;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
    } out_t;

    logic pixel_clock = 1'b0;
    logic pixel_reset_n = 1'b1;
    logic enable = 1'b0;
    logic s_de, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] s_x, s_y;
    logic d_de, d_hs, d_vs, d_ls, d_fs;
    logic [11:0] d_x, d_y;
`ifdef VTG_PREFETCH_EN
    logic [7:0] s_nx, s_ny;
    logic [11:0] d_nx, d_ny;
    logic s_na, d_na;
`endif

    int checks = 0, errors = 0;
    int s_hc = 0, s_vc = 0, d_hc = 0, d_vc = 0;
    out_t s_prev, d_prev;
    out_t s_q[$], d_q[$];
    int s_fs_cyc[$], d_ls_cyc[$];
    int s_de_cnt = 0, d_de_cnt = 0, d_hs_low = 0, d_fs_cnt = 0;

    video_timing_generator #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b0), .COORD_WIDTH(8)
    ) u_small (
        .pixel_clock(pixel_clock), .pixel_reset_n(pixel_reset_n), .enable(enable),
        .video_data_enable(s_de), .hsync(s_hs), .vsync(s_vs), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VTG_PREFETCH_EN
        , .next_x(s_nx), .next_y(s_ny), .next_active(s_na)
`endif
    );

    video_timing_generator u_dflt (
        .pixel_clock(pixel_clock), .pixel_reset_n(pixel_reset_n), .enable(enable),
        .video_data_enable(d_de), .hsync(d_hs), .vsync(d_vs), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VTG_PREFETCH_EN
        , .next_x(d_nx), .next_y(d_ny), .next_active(d_na)
`endif
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic out_t reset_out(input bit hp, input bit vp);
        out_t o;
        o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    task automatic model_step(input bit rst_on, input bit en,
                              input int ha, input int hf, input int hsw, input int hb,
                              input int va, input int vf, input int vsw, input int vb,
                              input bit hp, input bit vp,
                              inout int hc, inout int vc, inout out_t prev);
        out_t o;
        o = prev;
        if (rst_on) begin
            o = reset_out(hp, vp);
            hc = 0;
            vc = 0;
        end else if (en) begin
            o.de = (hc < ha) && (vc < va);
            o.hs = (hc >= ha + hf && hc < ha + hf + hsw) ? hp : ~hp;
            o.vs = (vc >= va + vf && vc < va + vf + vsw) ? vp : ~vp;
            o.x  = 12'(hc);
            o.y  = 12'(vc);
            o.ls = hc == 0;
            o.fs = hc == 0 && vc == 0;
            if (hc == ha + hf + hsw + hb - 1) begin
                hc = 0;
                vc = (vc == va + vf + vsw + vb - 1) ? 0 : vc + 1;
            end else begin
                hc++;
            end
        end else begin
            o.de = 1'b0;
            o.ls = 1'b0;
            o.fs = 1'b0;
        end
        prev = o;
    endtask

    function automatic out_t s_obs();
        out_t o;
        o.de = s_de; o.hs = s_hs; o.vs = s_vs; o.x = 12'(s_x); o.y = 12'(s_y); o.ls = s_ls; o.fs = s_fs;
        return o;
    endfunction

    function automatic out_t d_obs();
        out_t o;
        o.de = d_de; o.hs = d_hs; o.vs = d_vs; o.x = d_x; o.y = d_y; o.ls = d_ls; o.fs = d_fs;
        return o;
    endfunction

    task automatic compare_out(input string tag, input out_t got, input out_t exp);
        check({tag, ".de"}, 32'(got.de), 32'(exp.de));
        check({tag, ".hsync"}, 32'(got.hs), 32'(exp.hs));
        check({tag, ".vsync"}, 32'(got.vs), 32'(exp.vs));
        check({tag, ".x"}, 32'(got.x), 32'(exp.x));
        check({tag, ".y"}, 32'(got.y), 32'(exp.y));
        check({tag, ".line_start"}, 32'(got.ls), 32'(exp.ls));
        check({tag, ".frame_start"}, 32'(got.fs), 32'(exp.fs));
    endtask

    task automatic model_both(input bit rst_on, input bit en);
        model_step(rst_on, en, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b0, s_hc, s_vc, s_prev);
        s_q.push_back(s_prev);
        model_step(rst_on, en, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b0, 1'b0, d_hc, d_vc, d_prev);
        d_q.push_back(d_prev);
    endtask

    task automatic compare_both();
        compare_out("small", s_obs(), s_q.pop_front());
        compare_out("dflt", d_obs(), d_q.pop_front());
`ifdef VTG_PREFETCH_EN
        check("small.next_x", 32'(s_nx), s_hc);
        check("small.next_y", 32'(s_ny), s_vc);
        check("small.next_active", 32'(s_na), 32'(pixel_reset_n && s_hc < SHA && s_vc < SVA));
        check("dflt.next_x", 32'(d_nx), d_hc);
        check("dflt.next_y", 32'(d_ny), d_vc);
        check("dflt.next_active", 32'(d_na), 32'(pixel_reset_n && d_hc < DHA && d_vc < DVA));
`endif
    endtask

    task automatic cycle(input bit en);
        @(negedge pixel_clock);
        enable = en;
        model_both(!pixel_reset_n, en);
        @(posedge pixel_clock);
        #1;
        compare_both();
    endtask

    task automatic reset_pulse(input int hold);
        @(negedge pixel_clock);
        #2 pixel_reset_n = 1'b0;
        model_both(1'b1, enable);
        #1 compare_both();
        repeat (hold) cycle(1'b1);
        pixel_reset_n = 1'b1;
    endtask

    initial begin
        s_prev = reset_out(1'b1, 1'b0);
        d_prev = reset_out(1'b0, 1'b0);
        #1 pixel_reset_n = 1'b0;
        #3;
        model_both(1'b1, 1'b0);
        compare_both();
        cycle(1'b1);
        cycle(1'b0);
        pixel_reset_n = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            cycle(1'b1);
            if (s_fs) s_fs_cyc.push_back(i);
            if (i < 208 && s_de) s_de_cnt++;
            if (i < 800) begin
                d_de_cnt += int'(d_de);
                d_hs_low += int'(!d_hs);
            end
            if (d_ls) d_ls_cyc.push_back(i);
            if (d_fs) d_fs_cnt++;
        end
        check("small.fs_count", s_fs_cyc.size(), 17);
        if (s_fs_cyc.size() >= 2) begin
            check("small.fs_first", s_fs_cyc[0], 0);
            check("small.fs_period", s_fs_cyc[1] - s_fs_cyc[0], 104);
        end
        check("small.de_2frames", s_de_cnt, 48);
        check("dflt.de_line0", d_de_cnt, 640);
        check("dflt.hs_low_line0", d_hs_low, 96);
        check("dflt.ls_count", d_ls_cyc.size(), 3);
        if (d_ls_cyc.size() >= 2) check("dflt.ls_period", d_ls_cyc[1] - d_ls_cyc[0], 800);
        check("dflt.fs_count", d_fs_cnt, 1);
        cycle(1'b1);
        check("dflt.x_before_gap", 32'(d_x), 100);
        repeat (5) cycle(1'b0);
        check("dflt.x_held", 32'(d_x), 100);
        check("dflt.de_gap", 32'(d_de), 0);
        cycle(1'b1);
        check("dflt.x_resume", 32'(d_x), 101);
        cycle(1'b1);
        check("dflt.x_resume2", 32'(d_x), 102);
        repeat (300) cycle($urandom_range(0, 4) != 0);
        reset_pulse(3);
        cycle(1'b1);
        check("small.fs_after_reset", 32'(s_fs), 1);
        check("small.x_after_reset", 32'(s_x), 0);
        check("dflt.fs_after_reset", 32'(d_fs), 1);
        check("dflt.y_after_reset", 32'(d_y), 0);
        repeat (150) cycle(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
